// File: rtl/layer_out_serializer_pkg.sv
// layer_out_serializer_pkg: shared layer constants, FSM encoding and sizing helpers
package layer_out_serializer_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam int DEFAULT_NN         = 16;
    localparam int DEFAULT_DATA_WIDTH = 16;

    // Element counter width; a single-element vector still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: turns a captured parallel neuron-output vector into a gapless
// serial element stream, with a one-deep pending slot and a sticky drop flag.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int NN        = DEFAULT_NN,
    parameter int dataWidth = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam int CW = cnt_w(NN);
    localparam logic [CW-1:0] LAST = CW'(NN - 1);

    typedef logic [NN-1:0][dataWidth-1:0] vec_t;

    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    vec_t                 act_q, act_d;
    vec_t                 pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic                 x_valid_q, x_valid_d;
    logic [dataWidth-1:0] x_out_q, x_out_d;
    logic                 ovf_q, ovf_d;
    logic                 cap;
    logic                 last;
    logic                 unused_valid;

    // Only bit 0 strobes a capture; the remaining strobes are intentionally ignored.
    assign cap          = i_valid[0];
    assign unused_valid = ^i_valid;
    assign last         = (state_q == SHIFT) && (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        ovf_d       = ovf_q;
        if (state_q == IDLE) begin
            if (cap) begin
                state_d = SHIFT;
                cnt_d   = '0;
                act_d   = vec_t'(i_data);
            end
        end else if (!last) begin
            cnt_d = cnt_q + 1'b1;
            if (cap && !pend_full_q) begin
                pend_d      = vec_t'(i_data);
                pend_full_d = 1'b1;
            end else if (cap) begin
                ovf_d = 1'b1;
            end
        end else if (pend_full_q) begin
            // Hand over the waiting vector; a same-cycle strobe refills the slot without loss.
            act_d       = pend_q;
            cnt_d       = '0;
            pend_d      = cap ? vec_t'(i_data) : pend_q;
            pend_full_d = cap;
        end else if (cap) begin
            act_d = vec_t'(i_data);
            cnt_d = '0;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        x_valid_d = (state_d == SHIFT);
        x_out_d   = x_valid_d ? act_d[cnt_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            x_valid_q   <= 1'b0;
            x_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            x_valid_q   <= x_valid_d;
            x_out_q     <= x_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign x_valid  = x_valid_q;
    assign x_out    = x_out_q;
    assign busy     = (state_q == SHIFT) || pend_full_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: directed scenarios checked every cycle against a queue-based
// stream model, plus literal expectations on the collected output stream.
module tb_layer_out_serializer;

    localparam int NN = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NN-1:0]     i_valid;
    logic [NN*DW-1:0]  i_data;
    logic              x_valid;
    logic [DW-1:0]     x_out;
    logic              busy;
    logic              overflow;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    logic [DW-1:0] mq[$];
    logic          movf = 1'b0;
    logic [DW-1:0] seen[$];

    layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .x_valid(x_valid), .x_out(x_out), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NN*DW-1:0] vec(input logic [DW-1:0] base);
        logic [NN*DW-1:0] v;
        for (int k = 0; k < NN; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    // Stream model: the queue holds every element still owed, head = element on x_out now.
    // A new vector is accepted only if at most one full vector remains waiting after this cycle.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (i_valid[0]) begin
                if (mq.size() <= NN)
                    for (int k = 0; k < NN; k++) mq.push_back(i_data[k*DW +: DW]);
                else
                    movf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("x_valid", {31'd0, x_valid}, {31'd0, mq.size() > 0});
            chk("x_out", {16'd0, x_out}, {16'd0, (mq.size() > 0) ? mq[0] : 16'd0});
            chk("busy", {31'd0, busy}, {31'd0, mq.size() > 0});
            chk("overflow", {31'd0, overflow}, {31'd0, movf});
            if (x_valid) seen.push_back(x_out);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [DW-1:0] base);
        @(negedge clk);
        i_valid = 16'h0001;
        i_data  = vec(base);
        @(negedge clk);
        i_valid = '0;
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < 200);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        seen.delete();
    endtask

    task automatic wait_idle_keep(output int sz);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < 200);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        sz = seen.size();
    endtask

    initial begin
        int sz;
        rst     = 1'b1;
        i_valid = '0;
        i_data  = '0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_x_valid", {31'd0, x_valid}, 32'd0);
        chk("rst_x_out", {16'd0, x_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        seen.delete();

        strobe(16'h0100);
        wait_idle_keep(sz);
        chk("s1_count", sz, 32'd16);
        chk("s1_first", {16'd0, seen[0]}, 32'h0100);
        chk("s1_last", {16'd0, seen[15]}, 32'h010F);
        seen.delete();

        strobe(16'h0100);
        idle(4);
        strobe(16'h0200);
        wait_idle_keep(sz);
        chk("s2_count", sz, 32'd32);
        chk("s2_seam", {16'd0, seen[16]}, 32'h0200);
        chk("s2_last", {16'd0, seen[31]}, 32'h020F);
        chk("s2_overflow", {31'd0, overflow}, 32'd0);
        seen.delete();

        strobe(16'h0100);
        idle(4);
        strobe(16'h0200);
        idle(2);
        strobe(16'h0300);
        #1;
        chk("s3_overflow_set", {31'd0, overflow}, 32'd1);
        wait_idle_keep(sz);
        chk("s3_count", sz, 32'd32);
        chk("s3_last", {16'd0, seen[31]}, 32'h020F);
        chk("s3_overflow_sticky", {31'd0, overflow}, 32'd1);
        do_rst();
        #1;
        chk("s3_overflow_cleared", {31'd0, overflow}, 32'd0);
        seen.delete();

        strobe(16'h0100);
        idle(14);
        strobe(16'h0300);
        wait_idle_keep(sz);
        chk("s4_count", sz, 32'd32);
        chk("s4_seam_prev", {16'd0, seen[15]}, 32'h010F);
        chk("s4_seam", {16'd0, seen[16]}, 32'h0300);
        chk("s4_last", {16'd0, seen[31]}, 32'h030F);
        seen.delete();

        strobe(16'h0100);
        idle(6);
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 16'h0001;
        i_data  = vec(16'h0500);
        @(negedge clk);
        rst     = 1'b0;
        i_valid = '0;
        #1;
        chk("s5_x_valid", {31'd0, x_valid}, 32'd0);
        chk("s5_busy", {31'd0, busy}, 32'd0);
        chk("s5_overflow", {31'd0, overflow}, 32'd0);
        chk("s5_count", seen.size(), 32'd8);
        idle(3);
        chk("s5_ignored_strobe", seen.size(), 32'd8);
        strobe(16'h0100);
        wait_idle_keep(sz);
        chk("s5_restart_count", sz, 32'd24);
        chk("s5_restart_first", {16'd0, seen[8]}, 32'h0100);
        seen.delete();

        @(negedge clk);
        i_valid = 16'hFFFE;
        i_data  = vec(16'h0700);
        idle(5);
        i_valid = '0;
        idle(2);
        #1;
        chk("s6_count", seen.size(), 32'd0);
        chk("s6_busy", {31'd0, busy}, 32'd0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 The block SHALL have parameter NN, default 16: number of neuron outputs per vector.
REQ-002 The block SHALL have parameter dataWidth, default 16: bit width of one neuron output.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_valid, input, NN bits: per-neuron output-valid strobes from the upstream layer.
REQ-006 The block SHALL have port i_data, input, NN*dataWidth bits: packed neuron outputs; element k at [k*dataWidth +: dataWidth].
REQ-007 The block SHALL have port x_valid, output, 1 bit: serial element valid, fed to the next layer's input-valid.
REQ-008 The block SHALL have port x_out, output, dataWidth bits: serial element, fed to the next layer's data input.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a vector is being shifted out or is pending.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag set when a vector is dropped.

Function
REQ-011 The block SHALL take i_valid[0] as the vector-capture strobe; the other i_valid bits SHALL be ignored.
REQ-012 The block SHALL contain an active vector register, a one-deep pending vector register with a pending_full flag, an element counter of width clog2(NN), and two states, IDLE and SHIFT.
REQ-013 In IDLE, when i_valid[0]=1 at an edge, the block SHALL load i_data into the active register and enter SHIFT with counter=0.
REQ-014 In SHIFT, the block SHALL present element k of the active register on x_out with x_valid=1 for the cycle in which counter=k, for k=0..NN-1, on consecutive cycles with no gaps.
REQ-015 Latency SHALL be one cycle: with capture at edge t, element 0 is valid in the cycle following edge t.
REQ-016 x_out and x_valid SHALL be registered; when x_valid=0, x_out SHALL hold 0.
REQ-017 In the last element cycle (counter=NN-1): if pending_full=1, the pending vector SHALL move to the active register and shifting SHALL continue with counter=0 and no idle cycle; otherwise the block SHALL return to IDLE.
REQ-018 If i_valid[0]=1 in SHIFT, not in the last cycle, and pending_full=0, the block SHALL store i_data in the pending register and set pending_full.
REQ-019 If i_valid[0]=1 in SHIFT, not in the last cycle, and pending_full=1, the block SHALL drop the new vector, keep the pending vector, and set overflow.
REQ-020 If i_valid[0]=1 in the last cycle and pending_full=0, the new vector SHALL become active directly with no gap, and pending_full SHALL stay 0.
REQ-021 If i_valid[0]=1 in the last cycle and pending_full=1, the pending vector SHALL become active, the new vector SHALL be written to pending, and overflow SHALL NOT be set.
REQ-022 busy SHALL equal (state==SHIFT) OR pending_full.
REQ-023 overflow SHALL stay set until reset.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set state=IDLE, counter=0, pending_full=0, x_valid=0, x_out=0, busy=0, and overflow=0.
REQ-025 Reset during SHIFT SHALL abort the vector: x_valid SHALL be 0 from the next cycle, and no remaining elements SHALL be emitted.
REQ-026 i_valid SHALL be ignored in any cycle with rst=1.

Structure
REQ-027 The state encoding (IDLE=0, SHIFT=1) SHALL live in the shared network include/package alongside the other layer constants.
REQ-028 No sub-module SHALL be used; the registers, counter and FSM SHALL be inline.

Verification (NN=16, dataWidth=16, element k = 16'h0100+k)
REQ-029 A single strobe in IDLE SHALL produce x_valid high for exactly 16 consecutive cycles starting one cycle after capture, with x_out = 0100, 0101, ... 010F, and then IDLE with busy=0.
REQ-030 A second vector (16'h0200+k) strobed at counter=5 SHALL be output as 0200..020F immediately after 010F, with no gap, 32 valid cycles in total, and overflow=0.
REQ-031 A third vector strobed at counter=9 while pending is full SHALL set overflow=1, and the output stream SHALL be vectors 1 and 2 only.
REQ-032 A strobe at exactly counter=15 with pending empty SHALL produce 16 continuous elements of the new vector following 010F, with pending_full staying 0.
REQ-033 rst asserted at counter=7 SHALL give x_valid=0 from the next cycle, busy=0 and overflow=0; a later strobe SHALL restart cleanly at element 0.
REQ-034 With i_valid=16'hFFFE (bit 0 low), the block SHALL not capture and SHALL keep x_valid=0.
